mem_access_unit: RTL and testbench

Multi-cycle, parametrised load/store unit that sits between the execute stage and the CSR, DTCM and ITCM memory ports. It accepts one request at a time over a valid/ready handshake and decodes the target region from parametrised address windows. It steers store data onto byte lanes with byte enables, waits on a memory acknowledge with a timeout, and extracts and extends load data. It reports misaligned, unmapped and timeout faults instead of silently dropping the access.

---
 rtl/mem_access_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between execute and the CSR/DTCM/ITCM ports: decodes the window,
// steers store lanes, waits for ack with an optional timeout and extends load data.
module mem_access_unit #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] CSR_BASE      = 32'h0000,
  parameter logic [ADDR_WIDTH-1:0] CSR_SIZE      = 32'h1000,
  parameter logic [ADDR_WIDTH-1:0] DTCM_BASE     = 32'h1000,
  parameter logic [ADDR_WIDTH-1:0] DTCM_SIZE     = 32'h4000,
  parameter logic [ADDR_WIDTH-1:0] ITCM_BASE     = 32'h5000,
  parameter logic [ADDR_WIDTH-1:0] ITCM_SIZE     = 32'h4000,
  parameter bit                    ITCM_WRITABLE = 1'b1,
  parameter int                    TIMEOUT       = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_sign_extend,
  input  logic [1:0]            req_width,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  mem_req,
  output logic [1:0]            mem_region,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_UNMAP   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // The counter only needs to reach TIMEOUT-1: the cycle that would make it TIMEOUT ends the access.
  localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_e                  state_q, state_d;
  logic                    sext_q, sext_d;
  logic [1:0]              width_q, width_d;
  logic [1:0]              offs_q, offs_d;
  logic [CW-1:0]           waitCnt_q, waitCnt_d;
  logic                    memReq_q, memReq_d;
  logic [1:0]              memRegion_q, memRegion_d;
  logic                    memWe_q, memWe_d;
  logic [3:0]              memBe_q, memBe_d;
  logic [ADDR_WIDTH-1:0]   memAddr_q, memAddr_d;
  logic [31:0]             memWdata_q, memWdata_d;
  logic [31:0]             respData_q, respData_d;
  logic [1:0]              respErr_q, respErr_d;

  logic                    inCsr, inDtcm, inItcm;
  logic                    misaligned, unmapped;
  logic [1:0]              faultCode;
  logic [1:0]              decRegion;
  logic [3:0]              steerBe;
  logic [31:0]             steerData;
  logic                    timeoutHit;

  // Half-open window test done one bit wider so BASE+SIZE cannot wrap.
  function automatic logic inWindow(input logic [ADDR_WIDTH-1:0] a,
                                    input logic [ADDR_WIDTH-1:0] base,
                                    input logic [ADDR_WIDTH-1:0] size);
    logic [ADDR_WIDTH:0] x, lo, hi;
    x  = {1'b0, a};
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic [31:0] extractLoad(input logic [31:0] raw,
                                              input logic [1:0]  offs,
                                              input logic [1:0]  width,
                                              input logic        sext);
    logic [31:0] s;
    logic [31:0] res;
    s = raw >> {offs, 3'b000};
    case (width)
      2'd0:    res = sext ? {{24{s[7]}}, s[7:0]} : {24'b0, s[7:0]};
      2'd1:    res = sext ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
      default: res = s;
    endcase
    return res;
  endfunction

  always_comb begin
    inCsr  = inWindow(req_addr, CSR_BASE, CSR_SIZE);
    inDtcm = inWindow(req_addr, DTCM_BASE, DTCM_SIZE);
    inItcm = inWindow(req_addr, ITCM_BASE, ITCM_SIZE);

    if (inCsr)       decRegion = 2'd0;
    else if (inDtcm) decRegion = 2'd1;
    else             decRegion = 2'd2;

    misaligned = (req_width == 2'd3) ||
                 ((req_width == 2'd1) && req_addr[0]) ||
                 ((req_width == 2'd2) && (req_addr[1:0] != 2'b00));
    unmapped   = !(inCsr || inDtcm || inItcm) ||
                 (!inCsr && !inDtcm && inItcm && req_we && !ITCM_WRITABLE);

    if (misaligned)    faultCode = ERR_ALIGN;
    else if (unmapped) faultCode = ERR_UNMAP;
    else               faultCode = ERR_OK;

    case (req_width)
      2'd0: begin
        steerData = {4{req_wdata[7:0]}};
        steerBe   = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        steerData = {2{req_wdata[15:0]}};
        steerBe   = 4'b0011 << {req_addr[1], 1'b0};
      end
      default: begin
        steerData = req_wdata;
        steerBe   = 4'b1111;
      end
    endcase

    timeoutHit = (TIMEOUT > 0) && !mem_ack && (waitCnt_q == TO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sext_q      <= 1'b0;
      width_q     <= 2'd0;
      offs_q      <= 2'd0;
      waitCnt_q   <= '0;
      memReq_q    <= 1'b0;
      memRegion_q <= 2'd0;
      memWe_q     <= 1'b0;
      memBe_q     <= 4'b0;
      memAddr_q   <= '0;
      memWdata_q  <= 32'b0;
      respData_q  <= 32'b0;
      respErr_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      sext_q      <= sext_d;
      width_q     <= width_d;
      offs_q      <= offs_d;
      waitCnt_q   <= waitCnt_d;
      memReq_q    <= memReq_d;
      memRegion_q <= memRegion_d;
      memWe_q     <= memWe_d;
      memBe_q     <= memBe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      respData_q  <= respData_d;
      respErr_q   <= respErr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = (faultCode != ERR_OK) ? RESP : ACCESS;
      ACCESS:  if (mem_ack || timeoutHit) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory outputs only change on acceptance of a good request, so they stay put for the whole access.
  always_comb begin
    sext_d      = sext_q;
    width_d     = width_q;
    offs_d      = offs_q;
    waitCnt_d   = waitCnt_q;
    memReq_d    = memReq_q;
    memRegion_d = memRegion_q;
    memWe_d     = memWe_q;
    memBe_d     = memBe_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    respData_d  = respData_q;
    respErr_d   = respErr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          sext_d    = req_sign_extend;
          width_d   = req_width;
          offs_d    = req_addr[1:0];
          waitCnt_d = '0;
          if (faultCode != ERR_OK) begin
            respErr_d  = faultCode;
            respData_d = 32'b0;
          end else begin
            memReq_d    = 1'b1;
            memRegion_d = decRegion;
            memWe_d     = req_we;
            memBe_d     = steerBe;
            memAddr_d   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            memWdata_d  = steerData;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          memReq_d   = 1'b0;
          respErr_d  = ERR_OK;
          respData_d = memWe_q ? 32'b0 : extractLoad(mem_rdata, offs_q, width_q, sext_q);
        end else if (timeoutHit) begin
          memReq_d   = 1'b0;
          respErr_d  = ERR_TIMEOUT;
          respData_d = 32'b0;
        end else if (TIMEOUT > 0) begin
          waitCnt_d = waitCnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
  end

  assign resp_rdata = respData_q;
  assign resp_err   = respErr_q;
  assign mem_req    = memReq_q;
  assign mem_region = memRegion_q;
  assign mem_we     = memWe_q;
  assign mem_be     = memBe_q;
  assign mem_addr   = memAddr_q;
  assign mem_wdata  = memWdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset corner cases and
// randomized requests checked against an arithmetic model of the load/store rules.
module tb_mem_access_unit;

  localparam int TO = 15;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_sign_extend;
  logic [1:0]  req_width;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic [1:0]  mem_region;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        we;
    logic        sext;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackDelay;
    int          holdCycles;
    logic [1:0]  expErr;
    logic [31:0] expRdata;
    logic [1:0]  expRegion;
    logic [3:0]  expBe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
  } vec_t;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_sign_extend(req_sign_extend), .req_width(req_width),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_region(mem_region), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid       = 1'b1;
    req_we          = v.we;
    req_sign_extend = v.sext;
    req_width       = v.width;
    req_addr        = v.addr;
    req_wdata       = v.wdata;
  endtask

  function automatic vec_t mkVec(input logic we, input logic sext, input logic [1:0] width,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int ackDelay, input int hold,
                                 input logic [1:0] expErr, input logic [31:0] expRdata,
                                 input logic [1:0] expRegion, input logic [3:0] expBe,
                                 input logic [31:0] expAddr, input logic [31:0] expWdata);
    vec_t v;
    v.we = we; v.sext = sext; v.width = width; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.ackDelay = ackDelay; v.holdCycles = hold;
    v.expErr = expErr; v.expRdata = expRdata; v.expRegion = expRegion;
    v.expBe = expBe; v.expAddr = expAddr; v.expWdata = expWdata;
    return v;
  endfunction

  // Reference model: byte counts, modular arithmetic and address ranges.
  function automatic vec_t refModel(input vec_t v);
    vec_t   e;
    int     nb;
    int     off;
    longint val;
    longint lim;
    e = v;
    e.expRdata = 32'h0; e.expRegion = 2'd0; e.expBe = 4'h0; e.expAddr = 32'h0; e.expWdata = 32'h0;
    off = int'(v.addr % 4);
    nb  = (v.width == 2'd0) ? 1 : (v.width == 2'd1) ? 2 : (v.width == 2'd2) ? 4 : 0;
    if (nb == 0)            e.expErr = 2'd1;
    else if (off % nb != 0) e.expErr = 2'd1;
    else if (v.addr >= 32'h9000) e.expErr = 2'd2;
    else begin
      e.expRegion = (v.addr < 32'h1000) ? 2'd0 : (v.addr < 32'h5000) ? 2'd1 : 2'd2;
      e.expBe     = 4'(((1 << nb) - 1) << off);
      e.expAddr   = v.addr - 32'(off);
      for (int i = 0; i < 4; i++)
        e.expWdata = e.expWdata | (((v.wdata >> (8 * (i % nb))) & 32'hFF) << (8 * i));
      if (v.ackDelay >= TO) e.expErr = 2'd3;
      else begin
        e.expErr = 2'd0;
        if (!v.we) begin
          val = longint'(v.rdata >> (8 * off));
          if (nb < 4) begin
            lim = longint'(1) << (8 * nb);
            val = val % lim;
            if (v.sext && val >= lim / 2) val = val - lim;
          end
          e.expRdata = 32'(val);
        end
      end
    end
    return e;
  endfunction

  task automatic runTxn(input string tag, input vec_t v, input vec_t e);
    int cyc;
    int memCycles;
    int expCycles;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd1);
    applyStimulus(v);
    @(negedge clk);
    req_valid = 1'b0;
    if (e.expErr == 2'd1 || e.expErr == 2'd2) begin
      checkOutput({tag, " fault mem_req"}, 32'(mem_req), 32'd0);
    end else begin
      memCycles = 0;
      while (mem_req && memCycles < 40) begin
        memCycles++;
        checkOutput({tag, " mem_region"}, 32'(mem_region), 32'(e.expRegion));
        checkOutput({tag, " mem_we"}, 32'(mem_we), 32'(v.we));
        checkOutput({tag, " mem_be"}, 32'(mem_be), 32'(e.expBe));
        checkOutput({tag, " mem_addr"}, mem_addr, e.expAddr);
        if (v.we) checkOutput({tag, " mem_wdata"}, mem_wdata, e.expWdata);
        checkOutput({tag, " resp_valid in access"}, 32'(resp_valid), 32'd0);
        if (memCycles == v.ackDelay + 1) begin
          mem_ack = 1'b1; mem_rdata = v.rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
        @(negedge clk);
      end
      mem_ack = 1'b0;
      expCycles = (e.expErr == 2'd3) ? TO : v.ackDelay + 1;
      checkOutput({tag, " mem_req cycles"}, 32'(memCycles), 32'(expCycles));
    end
    // A late ack arrives while the response is pending and must not disturb it.
    if (e.expErr == 2'd3) begin
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    end
    for (int h = 0; h < v.holdCycles; h++) begin
      checkOutput({tag, " held resp_valid"}, 32'(resp_valid), 32'd1);
      checkOutput({tag, " held req_ready"}, 32'(req_ready), 32'd0);
      checkOutput({tag, " held resp_rdata"}, resp_rdata, e.expRdata);
      checkOutput({tag, " held mem_req"}, 32'(mem_req), 32'd0);
      req_valid = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    req_valid = 1'b0;
    checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    checkOutput({tag, " resp_err"}, 32'(resp_err), 32'(e.expErr));
    checkOutput({tag, " resp_rdata"}, resp_rdata, e.expRdata);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    mem_ack    = 1'b0;
    checkOutput({tag, " resp_valid dropped"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, " back to idle"}, 32'(req_ready), 32'd1);
  endtask

  vec_t tbl[15];
  vec_t rv;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_sign_extend = 1'b0;
    req_width = 2'd0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mem_be", 32'(mem_be), 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //                we    sext  w     addr          wdata         rdata         dly hold err   rdata         reg   be       addr          wdata
    tbl[0]  = mkVec(1'b1, 1'b0, 2'd0, 32'h0000_1003, 32'h1234_56A5, 32'h0,        0,  0,  2'd0, 32'h0,        2'd1, 4'b1000, 32'h0000_1000, 32'hA5A5_A5A5);
    tbl[1]  = mkVec(1'b0, 1'b1, 2'd0, 32'h0000_1002, 32'h0,         32'h0080_0000, 0, 0,  2'd0, 32'hFFFF_FF80, 2'd1, 4'b0100, 32'h0000_1000, 32'h0);
    tbl[2]  = mkVec(1'b0, 1'b0, 2'd0, 32'h0000_1002, 32'h0,         32'h0080_0000, 0, 0,  2'd0, 32'h0000_0080, 2'd1, 4'b0100, 32'h0000_1000, 32'h0);
    tbl[3]  = mkVec(1'b0, 1'b0, 2'd1, 32'h0000_1001, 32'h0,         32'h0,        0,  0,  2'd1, 32'h0,        2'd0, 4'b0000, 32'h0,         32'h0);
    tbl[4]  = mkVec(1'b1, 1'b0, 2'd2, 32'h0000_9000, 32'hCAFE_F00D, 32'h0,        0,  0,  2'd2, 32'h0,        2'd0, 4'b0000, 32'h0,         32'h0);
    tbl[5]  = mkVec(1'b0, 1'b0, 2'd2, 32'h0000_2004, 32'h0,         32'hDEAD_BEEF, 3, 0,  2'd0, 32'hDEAD_BEEF, 2'd1, 4'b1111, 32'h0000_2004, 32'h0);
    tbl[6]  = mkVec(1'b0, 1'b0, 2'd2, 32'h0000_5008, 32'h0,         32'h1111_1111, 99, 2, 2'd3, 32'h0,        2'd2, 4'b1111, 32'h0000_5008, 32'h0);
    tbl[7]  = mkVec(1'b0, 1'b1, 2'd1, 32'h0000_0006, 32'h0,         32'h8001_0000, 1, 5,  2'd0, 32'hFFFF_8001, 2'd0, 4'b1100, 32'h0000_0004, 32'h0);
    tbl[8]  = mkVec(1'b0, 1'b0, 2'd3, 32'h0000_1000, 32'h0,         32'h0,        0,  0,  2'd1, 32'h0,        2'd0, 4'b0000, 32'h0,         32'h0);
    tbl[9]  = mkVec(1'b1, 1'b0, 2'd1, 32'h0000_5002, 32'hABCD_1234, 32'h0,        2,  1,  2'd0, 32'h0,        2'd2, 4'b1100, 32'h0000_5000, 32'h1234_1234);
    tbl[10] = mkVec(1'b0, 1'b0, 2'd0, 32'h0000_4FFF, 32'h0,         32'h7F00_0000, 0, 0,  2'd0, 32'h0000_007F, 2'd1, 4'b1000, 32'h0000_4FFC, 32'h0);
    tbl[11] = mkVec(1'b0, 1'b0, 2'd2, 32'h0000_8FFC, 32'h0,         32'h0102_0304, 14, 0, 2'd0, 32'h0102_0304, 2'd2, 4'b1111, 32'h0000_8FFC, 32'h0);
    tbl[12] = mkVec(1'b1, 1'b0, 2'd2, 32'h0000_0FFC, 32'h5566_7788, 32'h0,        0,  0,  2'd0, 32'h0,        2'd0, 4'b1111, 32'h0000_0FFC, 32'h5566_7788);
    tbl[13] = mkVec(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFC, 32'h1,         32'h0,        0,  0,  2'd2, 32'h0,        2'd0, 4'b0000, 32'h0,         32'h0);
    tbl[14] = mkVec(1'b0, 1'b0, 2'd1, 32'h0000_9001, 32'h0,         32'h0,        0,  0,  2'd1, 32'h0,        2'd0, 4'b0000, 32'h0,         32'h0);

    for (int i = 0; i < 15; i++)
      runTxn($sformatf("vec%0d", i), tbl[i], tbl[i]);

    // Reset pulsed in the middle of an access kills it with no response.
    rv = tbl[0];
    applyStimulus(rv);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("midreset mem_req before", 32'(mem_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset mem_req", 32'(mem_req), 32'd0);
    checkOutput("midreset req_ready", 32'(req_ready), 32'd1);
    checkOutput("midreset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("midreset mem_be", 32'(mem_be), 32'd0);
    checkOutput("midreset mem_we", 32'(mem_we), 32'd0);
    checkOutput("midreset mem_wdata", mem_wdata, 32'h0);
    checkOutput("midreset mem_addr", mem_addr, 32'h0);
    checkOutput("midreset mem_region", 32'(mem_region), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("post-reset no resp", 32'(resp_valid), 32'd0);
      checkOutput("post-reset no mem_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end

    for (int n = 0; n < 120; n++) begin
      rv.we    = 1'($urandom_range(0, 1));
      rv.sext  = 1'($urandom_range(0, 1));
      rv.width = 2'($urandom_range(0, 3));
      rv.addr  = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 32'h9800)) : $urandom;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.ackDelay   = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, 5);
      rv.holdCycles = $urandom_range(0, 2);
      runTxn($sformatf("rand%0d", n), rv, refModel(rv));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
